// File: rtl/buzz_arbiter_pkg.sv
// Shared constants for the buzzer arbiter: state encoding and parameter defaults.
// Display and LED drivers import this package to decode state_o.
package buzz_arbiter_pkg;

   localparam int unsigned N_PLAYERS_DEF   = 4;
   localparam int unsigned TICK_CYCLES_DEF = 50_000_000;
   localparam int unsigned ANSWER_SECS_DEF = 5;
   localparam int unsigned SECS_W          = 4;
   localparam int unsigned STATE_W         = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ANSWER = 2'd2,
      ST_UNUSED = 2'd3
   } state_t;

endpackage

// File: rtl/buzz_arbiter_rr_pick.sv
// Combinational round-robin selector: grants the first requester at or after i_ptr.
module buzz_arbiter_rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant_c
);

   logic             w_found;
   logic [PTR_W-1:0] w_idx;

   always_comb begin
      o_grant_c = '0;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int i = 0; i < int'(N); i++) begin
         w_idx = PTR_W'((int'(i_ptr) + i) % int'(N));
         if (!w_found && i_req[w_idx]) begin
            o_grant_c[w_idx] = 1'b1;
            w_found          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/buzz_arbiter.sv
// Quiz buzzer arbiter: synchronises player buttons, latches the first eligible
// press, runs the answer-window countdown and tracks locked-out players.
module buzz_arbiter
   import buzz_arbiter_pkg::*;
#(
   parameter int unsigned N_PLAYERS   = N_PLAYERS_DEF,
   parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF,
   parameter int unsigned ANSWER_SECS = ANSWER_SECS_DEF
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_n,
   input  logic [N_PLAYERS-1:0] btn_n,
   input  logic                 arm,
   input  logic                 judge_ok,
   input  logic                 judge_bad,
   output logic [N_PLAYERS-1:0] winner,
   output logic [N_PLAYERS-1:0] locked,
   output logic [SECS_W-1:0]    secs,
   output logic [STATE_W-1:0]   state_o,
   output logic                 round_done
);

   localparam int unsigned PTR_W  = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1;
   localparam int unsigned TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [N_PLAYERS-1:0] ALL_ONES = {N_PLAYERS{1'b1}};

   logic [N_PLAYERS-1:0] r_sync1;
   logic [N_PLAYERS-1:0] r_sync2;
   logic [N_PLAYERS-1:0] r_prev;
   state_t               r_state;
   logic [N_PLAYERS-1:0] r_winner;
   logic [N_PLAYERS-1:0] r_locked;
   logic [SECS_W-1:0]    r_secs;
   logic                 r_done;
   logic [PTR_W-1:0]     r_ptr;
   logic [TICK_W-1:0]    r_tick;

   state_t               w_state_nxt;
   logic [N_PLAYERS-1:0] w_winner_nxt;
   logic [N_PLAYERS-1:0] w_locked_nxt;
   logic [SECS_W-1:0]    w_secs_nxt;
   logic                 w_done_nxt;
   logic [PTR_W-1:0]     w_ptr_nxt;
   logic [TICK_W-1:0]    w_tick_nxt;
   logic [N_PLAYERS-1:0] w_lock_all;

   logic [N_PLAYERS-1:0] w_press;
   logic [N_PLAYERS-1:0] w_elig;
   logic [N_PLAYERS-1:0] w_grant;
   logic                 w_tick_wrap;
   logic                 w_timeout;

   // Two-flop synchroniser plus a history flop for falling-edge detection.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= ALL_ONES;
         r_sync2 <= ALL_ONES;
         r_prev  <= ALL_ONES;
      end else begin
         r_sync1 <= btn_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_press     = r_prev & ~r_sync2;
   assign w_elig      = w_press & ~r_locked;
   assign w_tick_wrap = (r_tick == TICK_W'(TICK_CYCLES - 1));
   assign w_timeout   = w_tick_wrap && (r_secs == SECS_W'(1));

   buzz_arbiter_rr_pick #(
      .N     (N_PLAYERS),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_req     (w_elig),
      .i_ptr     (r_ptr),
      .o_grant_c (w_grant)
   );

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_winner <= '0;
         r_locked <= '0;
         r_secs   <= '0;
         r_done   <= 1'b0;
         r_ptr    <= '0;
         r_tick   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_winner <= w_winner_nxt;
         r_locked <= w_locked_nxt;
         r_secs   <= w_secs_nxt;
         r_done   <= w_done_nxt;
         r_ptr    <= w_ptr_nxt;
         r_tick   <= w_tick_nxt;
      end
   end

   // Next-state logic; judge_ok outranks judge_bad, which outranks a timeout.
   always_comb begin
      w_state_nxt  = r_state;
      w_winner_nxt = r_winner;
      w_locked_nxt = r_locked;
      w_secs_nxt   = r_secs;
      w_done_nxt   = 1'b0;
      w_ptr_nxt    = r_ptr;
      w_tick_nxt   = r_tick;
      w_lock_all   = r_locked | r_winner;

      case (r_state)
         ST_IDLE: begin
            w_winner_nxt = '0;
            w_tick_nxt   = '0;
            if (arm) begin
               w_state_nxt  = ST_ARMED;
               w_locked_nxt = '0;
            end
         end
         ST_ARMED: begin
            w_winner_nxt = '0;
            w_tick_nxt   = '0;
            if (|w_elig) begin
               w_state_nxt  = ST_ANSWER;
               w_winner_nxt = w_grant;
               w_secs_nxt   = SECS_W'(ANSWER_SECS);
               for (int i = 0; i < int'(N_PLAYERS); i++) begin
                  if (w_grant[i]) begin
                     w_ptr_nxt = (i == int'(N_PLAYERS) - 1) ? '0 : PTR_W'(i + 1);
                  end
               end
            end
         end
         ST_ANSWER: begin
            if (judge_ok) begin
               w_state_nxt  = ST_IDLE;
               w_winner_nxt = '0;
               w_tick_nxt   = '0;
               w_done_nxt   = 1'b1;
            end else if (judge_bad || w_timeout) begin
               w_locked_nxt = w_lock_all;
               w_winner_nxt = '0;
               w_secs_nxt   = '0;
               w_tick_nxt   = '0;
               if (w_lock_all == ALL_ONES) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_ARMED;
               end
            end else if (w_tick_wrap) begin
               w_tick_nxt = '0;
               w_secs_nxt = r_secs - SECS_W'(1);
            end else begin
               w_tick_nxt = r_tick + TICK_W'(1);
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_winner_nxt = '0;
            w_tick_nxt   = '0;
         end
      endcase
   end

   assign winner     = r_winner;
   assign locked     = r_locked;
   assign secs       = r_secs;
   assign state_o    = r_state;
   assign round_done = r_done;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter with a short tick (10 cycles per second).
module tb_buzz_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_n;
   logic       arm, ok, bad;
   logic [3:0] winner, locked, secs;
   logic [1:0] state_o;
   logic       round_done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] btn_n;
      logic       arm;
      logic       ok;
      logic       bad;
      logic [3:0] winner;
      logic [3:0] locked;
      logic [3:0] secs;
      logic [1:0] state;
      logic       done;
   } vec_t;

   vec_t vecs[13];

   buzz_arbiter #(
      .N_PLAYERS   (4),
      .TICK_CYCLES (10),
      .ANSWER_SECS (5)
   ) dut (
      .CLOCK_50   (clk),
      .reset_n    (rst_n),
      .btn_n      (btn_n),
      .arm        (arm),
      .judge_ok   (ok),
      .judge_bad  (bad),
      .winner     (winner),
      .locked     (locked),
      .secs       (secs),
      .state_o    (state_o),
      .round_done (round_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({winner, locked, secs, state_o, round_done});
   endfunction

   // Hold a button pattern for three cycles, then check the latched winner.
   task automatic press_check(input logic [3:0] b, input logic [3:0] expw, input string nm);
      btn_n = b;
      step();
      step();
      step();
      check(nm, 32'(winner), 32'(expw));
      btn_n = 4'b1111;
   endtask

   initial begin
      logic [3:0] exp_secs;

      rst_n = 1'b0;
      btn_n = 4'b1111;
      arm   = 1'b0;
      ok    = 1'b0;
      bad   = 1'b0;

      //              btn      arm   ok    bad   winner   locked   secs  st    done
      vecs[0]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 2'd1, 1'b0};
      vecs[1]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 2'd1, 1'b0};
      vecs[2]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 2'd1, 1'b0};
      vecs[3]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'd5, 2'd2, 1'b0};
      vecs[4]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'd0, 2'd1, 1'b0};
      vecs[5]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'd0, 2'd1, 1'b0};
      vecs[6]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'd0, 2'd1, 1'b0};
      vecs[7]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0100, 4'd5, 2'd2, 1'b0};
      vecs[8]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'd5, 2'd0, 1'b1};
      vecs[9]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'd5, 2'd0, 1'b0};
      vecs[10] = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd5, 2'd1, 1'b0};
      vecs[11] = '{4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'd5, 2'd1, 1'b0};
      vecs[12] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd5, 2'd1, 1'b0};

      #12;
      check("reset_outputs", outs(), 32'd0);
      #10;
      rst_n = 1'b1;
      step();

      // Arm, single press, judge bad, simultaneous press with pointer, judge ok.
      for (int k = 0; k < 13; k++) begin
         btn_n = vecs[k].btn_n;
         arm   = vecs[k].arm;
         ok    = vecs[k].ok;
         bad   = vecs[k].bad;
         step();
         check($sformatf("vec%0d", k), outs(),
               32'({vecs[k].winner, vecs[k].locked, vecs[k].secs, vecs[k].state, vecs[k].done}));
      end
      btn_n = 4'b1111;
      arm   = 1'b0;
      ok    = 1'b0;
      bad   = 1'b0;

      // Countdown to timeout with player 1.
      press_check(4'b1101, 4'b0010, "p1_win");
      for (int k = 1; k <= 50; k++) begin
         step();
         exp_secs = (k >= 50) ? 4'd0 : 4'(5 - k / 10);
         check($sformatf("secs_t%0d", k), 32'(secs), 32'(exp_secs));
         if (k < 50) begin
            if (k % 10 == 9) check($sformatf("answer_t%0d", k), 32'(state_o), 32'd2);
         end else begin
            check("timeout_state", 32'({state_o, winner, locked}), 32'({2'd1, 4'b0000, 4'b0010}));
         end
      end

      // Lock players 0 and 2, confirm locked press is ignored, then player 3 times out.
      press_check(4'b1110, 4'b0001, "p0_win");
      bad = 1'b1;
      step();
      bad = 1'b0;
      check("lock_p0", 32'({state_o, locked}), 32'({2'd1, 4'b0011}));
      press_check(4'b1011, 4'b0100, "p2_win");
      bad = 1'b1;
      step();
      bad = 1'b0;
      check("lock_p2", 32'({state_o, locked}), 32'({2'd1, 4'b0111}));
      press_check(4'b1110, 4'b0000, "locked_press");
      check("locked_press_state", 32'(state_o), 32'd1);
      press_check(4'b0111, 4'b1000, "p3_win");
      repeat (49) step();
      check("p3_pre_timeout", 32'({state_o, secs}), 32'({2'd2, 4'd1}));
      step();
      check("all_locked_end", 32'({state_o, round_done, locked}), 32'({2'd0, 1'b1, 4'b1111}));
      step();
      check("done_one_cycle", 32'(round_done), 32'd0);

      // judge_ok on the same cycle as the final timeout tick.
      arm = 1'b1;
      step();
      arm = 1'b0;
      press_check(4'b1110, 4'b0001, "p0_win_ok");
      repeat (49) step();
      ok = 1'b1;
      step();
      ok = 1'b0;
      check("ok_beats_timeout", 32'({state_o, round_done, locked, secs}),
            32'({2'd0, 1'b1, 4'b0000, 4'd1}));

      // Reset in the middle of an answer window.
      arm = 1'b1;
      step();
      arm = 1'b0;
      press_check(4'b1101, 4'b0010, "p1_win_rst");
      repeat (25) step();
      check("secs_before_reset", 32'({state_o, secs}), 32'({2'd2, 4'd3}));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", outs(), 32'd0);
      step();
      check("reset_held", outs(), 32'd0);
      rst_n = 1'b1;
      press_check(4'b1011, 4'b0000, "press_no_arm");
      check("idle_after_reset", 32'({state_o, round_done}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
